// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: decoder jump codes,
// the NOP encoding, the fetch FSM states and the IF/ID register layout.
package instr_fetch_pkg;

  localparam logic [1:0] JUMP_J   = 2'b00;
  localparam logic [1:0] JUMP_SEQ = 2'b01;
  localparam logic [1:0] JUMP_JR  = 2'b10;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential PC+4 plus the prioritised
// redirect target (j/jal, then jr, then taken branch).
module pc_next_sel
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  jump,
  input  logic        branch_taken,
  input  logic [29:0] branch_word,
  input  logic [29:0] jr_word,
  input  logic [25:0] jump_index,
  input  logic [3:0]  pc_region,
  output logic [31:0] seq_pc,
  output logic [31:0] redirect_pc,
  output logic        redirect_req
);

  // PC+4 wraps naturally in 32 bits: 32'hFFFF_FFFC + 4 -> 32'h0.
  assign seq_pc = pc + 32'd4;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    redirect_pc  = seq_pc;
    redirect_req = 1'b0;
    case (jump)
      JUMP_J: begin
        redirect_pc  = {pc_region, jump_index, 2'b00};
        redirect_req = 1'b1;
      end
      JUMP_JR: begin
        redirect_pc  = {jr_word, 2'b00};
        redirect_req = 1'b1;
      end
      JUMP_SEQ, 2'b11: begin
        if (branch_taken) begin
          redirect_pc  = {branch_word, 2'b00};
          redirect_req = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, BOOT/RUN/HOLD
// control FSM and a counter of valid instructions delivered to decode.
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [1:0]  jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jr_target_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  ifid_t       ifid_q;

  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic        redirect_req;
  logic        take_redirect;
  logic        unused_addr_bits;

  // Targets are forced word-aligned, so their low two bits never matter.
  assign unused_addr_bits = ^{branch_target_i[1:0], jr_target_i[1:0]};

  pc_next_sel u_pc_next_sel (
    .pc           (pc_q),
    .jump         (jump_i),
    .branch_taken (branch_taken_i),
    .branch_word  (branch_target_i[31:2]),
    .jr_word      (jr_target_i[31:2]),
    .jump_index   (ifid_q.instr[25:0]),
    .pc_region    (ifid_q.pc_plus4[31:28]),
    .seq_pc       (seq_pc),
    .redirect_pc  (redirect_pc),
    .redirect_req (redirect_req)
  );

  // Redirect decoding comes from the instruction in IF/ID, so it is only
  // trustworthy when that instruction is real and decode is not stalled.
  assign take_redirect = ifid_q.valid && !stall_i && redirect_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= 32'h0;
      ifid_q  <= BUBBLE;
      cnt_q   <= 32'h0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          pc_q    <= 32'h0;
          ifid_q  <= BUBBLE;
        end
        RUN, HOLD: begin
          state_q <= (stall_i && !flush_i) ? HOLD : RUN;
          if (flush_i) begin
            ifid_q <= BUBBLE;
            if (take_redirect) pc_q <= redirect_pc;
          end else if (stall_i) begin
            pc_q   <= pc_q;
            ifid_q <= ifid_q;
          end else if (take_redirect) begin
            pc_q   <= redirect_pc;
            ifid_q <= BUBBLE;
          end else begin
            pc_q   <= seq_pc;
            ifid_q <= '{instr: imem_data_i, pc_plus4: seq_pc, valid: 1'b1};
            cnt_q  <= cnt_q + 32'd1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = ifid_q.instr;
  assign pc_plus4_o  = ifid_q.pc_plus4;
  assign valid_o     = ifid_q.valid;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: each stimulus step queues the expected
// IF/ID, PC, counter and state, which are popped and compared after the edge.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  jump;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        valid;
  logic [31:0] fetch_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] cnt;
    state_t      st;
  } exp_t;

  exp_t sb[$];

  instr_fetch dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .jump_i          (jump),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jr_target_i     (jr_target),
    .imem_data_i     (imem_data),
    .imem_addr_o     (imem_addr),
    .instr_o         (instr),
    .pc_plus4_o      (pc_plus4),
    .valid_o         (valid),
    .fetch_cnt_o     (fetch_cnt)
  );

  // Instruction memory: address-tagged words, plus a j 0x40 at address 0x8.
  assign imem_data = (imem_addr == 32'h8) ? 32'h0800_0010 : (imem_addr ^ 32'hA5A5_0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pp4,
                      input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                      input state_t e_st);
    exp_t e;
    e.tag = tag; e.instr = e_instr; e.pc_plus4 = e_pp4; e.valid = e_valid;
    e.pc = e_pc; e.cnt = e_cnt; e.st = e_st;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: DUT step with no expectation queued");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".instr"}, instr, e.instr);
      check({e.tag, ".pc_plus4"}, pc_plus4, e.pc_plus4);
      check({e.tag, ".valid"}, {31'h0, valid}, {31'h0, e.valid});
      check({e.tag, ".pc"}, imem_addr, e.pc);
      check({e.tag, ".cnt"}, fetch_cnt, e.cnt);
      check({e.tag, ".state"}, 32'(dut.state_q), 32'(e.st));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic drive(input logic s, input logic f, input logic [1:0] j, input logic b,
                       input logic [31:0] bt, input logic [31:0] jt);
    stall = s; flush = f; jump = j; branch_taken = b; branch_target = bt; jr_target = jt;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    #12;
    push("reset", NOP, 32'h0, 1'b0, 32'h0, 32'h0, BOOT);
    compare_front();
    rst = 1'b0;

    // Boot bubble, then sequential fetch from address 0.
    push("boot", NOP, 32'h0, 1'b0, 32'h0, 32'h0, RUN);                      tick();
    push("seq0", 32'hA5A5_0000, 32'h4, 1'b1, 32'h4, 32'h1, RUN);            tick();
    push("seq1", 32'hA5A5_0004, 32'h8, 1'b1, 32'h8, 32'h2, RUN);            tick();
    push("seq2", 32'h0800_0010, 32'hC, 1'b1, 32'hC, 32'h3, RUN);            tick();

    // j 0x40 held in IF/ID.
    drive(1'b0, 1'b0, JUMP_J, 1'b0, 32'h0, 32'h0);
    push("jump", NOP, 32'h0, 1'b0, 32'h40, 32'h3, RUN);                     tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("jump_tgt", 32'hA5A5_0040, 32'h44, 1'b1, 32'h44, 32'h4, RUN);      tick();
    push("seq3", 32'hA5A5_0044, 32'h48, 1'b1, 32'h48, 32'h5, RUN);          tick();

    // Stall while a jr is presented: everything freezes for three edges.
    drive(1'b1, 1'b0, JUMP_JR, 1'b0, 32'h0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("stall%0d", i), 32'hA5A5_0044, 32'h48, 1'b1, 32'h48, 32'h5, HOLD);
      tick();
    end
    drive(1'b0, 1'b0, JUMP_JR, 1'b0, 32'h0, 32'h100);
    push("stall_jr", NOP, 32'h0, 1'b0, 32'h100, 32'h5, RUN);                tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("jr_tgt", 32'hA5A5_0100, 32'h104, 1'b1, 32'h104, 32'h6, RUN);      tick();

    // Flush overrides stall: bubble, PC unchanged.
    drive(1'b1, 1'b1, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("flush_stall", NOP, 32'h0, 1'b0, 32'h104, 32'h6, RUN);             tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("refetch", 32'hA5A5_0104, 32'h108, 1'b1, 32'h108, 32'h7, RUN);     tick();

    // Taken branch with a misaligned target is word-aligned.
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b1, 32'h203, 32'h0);
    push("branch", NOP, 32'h0, 1'b0, 32'h200, 32'h7, RUN);                  tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("br_tgt", 32'hA5A5_0200, 32'h204, 1'b1, 32'h204, 32'h8, RUN);      tick();

    // Flush coinciding with an honoured jr still redirects the PC.
    drive(1'b0, 1'b1, JUMP_JR, 1'b0, 32'h0, 32'h300);
    push("flush_jr", NOP, 32'h0, 1'b0, 32'h300, 32'h8, RUN);                tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("fj_tgt", 32'hA5A5_0300, 32'h304, 1'b1, 32'h304, 32'h9, RUN);      tick();

    // jr has priority over a taken branch.
    drive(1'b0, 1'b0, JUMP_JR, 1'b1, 32'h500, 32'h400);
    push("prio_jr", NOP, 32'h0, 1'b0, 32'h400, 32'h9, RUN);                 tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("prio_tgt", 32'hA5A5_0400, 32'h404, 1'b1, 32'h404, 32'hA, RUN);    tick();

    // Wrap at the top of the address space; a branch seen on a bubble is ignored.
    drive(1'b0, 1'b0, JUMP_JR, 1'b0, 32'h0, 32'hFFFF_FFFF);
    push("to_top", NOP, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hA, RUN);            tick();
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b1, 32'h800, 32'h0);
    push("wrap", 32'h5A5A_FFFC, 32'h0, 1'b1, 32'h0, 32'hB, RUN);            tick();

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("hold", 32'h5A5A_FFFC, 32'h0, 1'b1, 32'h0, 32'hB, HOLD);           tick();
    #2 rst = 1'b1;
    #1;
    push("async_rst", NOP, 32'h0, 1'b0, 32'h0, 32'h0, BOOT);
    compare_front();
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, JUMP_SEQ, 1'b0, 32'h0, 32'h0);
    push("reboot", NOP, 32'h0, 1'b0, 32'h0, 32'h0, RUN);                    tick();
    push("reseq0", 32'hA5A5_0000, 32'h4, 1'b1, 32'h4, 32'h1, RUN);          tick();

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
